// File: rtl/aq_spsram_256x59_ctrl.sv
// aq_spsram_256x59_ctrl: initiator-side controller for the 256x59 IFU single-port SRAM macro.
// Define AQ_SPSRAM_CTRL_INIT_EN to include the post-reset / on-request invalidation sweep.
module aq_spsram_256x59_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 59,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  init_start,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);
    logic                  sweep;
    logic                  acc;
    logic                  wr;
    logic                  rd_q;
    logic [ADDR_WIDTH-1:0] cnt;
`ifdef AQ_SPSRAM_CTRL_INIT_EN
    typedef enum logic {INIT, READY} state_t;
    state_t state;
    assign sweep   = state == INIT;
    assign req_rdy = ~sweep & ~init_start;
    // cnt wraps 255 -> 0 on the same edge that leaves INIT
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
        end else if (sweep) begin
            cnt <= cnt + ADDR_WIDTH'(1);
            if (&cnt) begin
                state     <= READY;
                init_done <= 1'b1;
            end
        end else if (init_start) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
        end
    end
`else
    logic unused_init;
    assign unused_init = init_start;
    assign sweep       = 1'b0;
    assign cnt         = '0;
    assign req_rdy     = 1'b1;
    assign init_done   = 1'b1;
`endif
    assign acc       = req_vld & req_rdy;
    assign wr        = acc & req_wr;
    assign rsp_rdata = sram_q;
    // read flag is shifted twice so rsp_vld lines up with Q from the SRAM
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sram_a    <= '0;
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
            sram_d    <= '0;
            rd_q      <= 1'b0;
            rsp_vld   <= 1'b0;
        end else begin
            rd_q      <= acc & ~req_wr;
            rsp_vld   <= rd_q;
            sram_cen  <= ~(sweep | acc);
            sram_gwen <= ~(sweep | wr);
            sram_wen  <= sweep ? '0 : wr ? ~req_wmask : '1;
            if (sweep | acc) sram_a <= sweep ? cnt : req_addr;
            if (sweep | wr) sram_d <= sweep ? INIT_VALUE : req_wdata;
        end
    end
endmodule

// File: tb/tb_aq_spsram_256x59_ctrl.sv
// tb_aq_spsram_256x59_ctrl: directed table, corner sequences and random traffic against a
// transaction-level model of the controller plus a behavioural SRAM macro.
module tb_aq_spsram_256x59_ctrl;
    localparam int AW = 8;
    localparam int DW = 59;
    localparam logic [DW-1:0] IV   = '0;
    localparam logic [DW-1:0] ONES = '1;
`ifdef AQ_SPSRAM_CTRL_INIT_EN
    localparam bit INIT_BUILD = 1'b1;
`else
    localparam bit INIT_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_vld = 1'b0, req_wr = 1'b0, init_start = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0, req_wmask = '0;
    logic          req_rdy, rsp_vld, init_done, sram_cen, sram_gwen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] rsp_rdata, sram_wen, sram_d;
    logic [DW-1:0] sram_q = '0;
    int vec = 0, errs = 0;

    always #5 clk = ~clk;

    aq_spsram_256x59_ctrl dut (
        .forever_cpuclk(clk), .cpurst_b(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata),
        .init_start(init_start), .init_done(init_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    // behavioural SRAM macro: one-cycle registered Q, active-low per-bit write enables
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else sram_q <= mem[sram_a];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference model: predicts pin values after the next edge and the response schedule
    typedef struct { int cyc; logic [DW-1:0] data; } rsp_t;
    rsp_t          rq[$];
    logic [DW-1:0] ref_mem [256];
    logic          m_init = 1'b0;
    int            m_idx = 0;
    int            cyc = 0;
    logic          p_cen = 1'b1, p_gwen = 1'b1;
    logic [DW-1:0] p_wen = '1, p_d = '0;
    logic [AW-1:0] p_a = '0;

    task automatic idle();
        p_cen = 1'b1;
        p_gwen = 1'b1;
        p_wen = ONES;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                rq.delete();
                m_init = INIT_BUILD;
                m_idx = 0;
                chk("rst_cen", sram_cen, 1);
                chk("rst_gwen", sram_gwen, 1);
                chk("rst_wen", sram_wen, ONES);
                chk("rst_a", sram_a, 0);
                chk("rst_d", sram_d, 0);
                chk("rst_rsp_vld", rsp_vld, 0);
                chk("rst_init_done", init_done, !INIT_BUILD);
                chk("rst_req_rdy", req_rdy, !INIT_BUILD);
                idle();
                p_a = '0;
                p_d = '0;
            end else begin
                if (rq.size() > 0 && rq[0].cyc == cyc) begin
                    chk("rsp_vld", rsp_vld, 1);
                    chk("rsp_rdata", rsp_rdata, rq[0].data);
                    void'(rq.pop_front());
                end else chk("rsp_vld", rsp_vld, 0);
                chk("init_done", init_done, !m_init);
                chk("req_rdy", req_rdy, !m_init && !(INIT_BUILD && init_start));
                chk("cen", sram_cen, p_cen);
                chk("gwen", sram_gwen, p_gwen);
                chk("wen", sram_wen, p_wen);
                if (!p_cen) chk("a", sram_a, p_a);
                if (!p_cen && !p_gwen) chk("d", sram_d, p_d);
                if (m_init) begin
                    p_cen = 1'b0;
                    p_gwen = 1'b0;
                    p_wen = '0;
                    p_a = AW'(m_idx);
                    p_d = IV;
                    ref_mem[m_idx] = IV;
                    m_init = m_idx != 255;
                    m_idx = (m_idx + 1) % 256;
                end else if (INIT_BUILD && init_start) begin
                    idle();
                    m_init = 1'b1;
                    m_idx = 0;
                end else if (req_vld) begin
                    p_cen = 1'b0;
                    p_a = req_addr;
                    p_gwen = !req_wr;
                    if (req_wr) begin
                        p_wen = ~req_wmask;
                        p_d = req_wdata;
                        ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
                    end else begin
                        p_wen = ONES;
                        rq.push_back('{cyc + 2, ref_mem[req_addr]});
                    end
                end else idle();
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (!init_done && n < 400) begin
            step();
            n++;
        end
        chk("init_done_timeout", init_done, 1);
    endtask

    task automatic sweep_check(input string nm);
        for (int i = 0; i < 256; i++) begin
            step();
            chk({nm, "_a"}, sram_a, i);
            chk({nm, "_cen"}, sram_cen, 0);
            chk({nm, "_wen"}, sram_wen, 0);
            chk({nm, "_done"}, init_done, i == 255);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] wmask;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t          tbl[9];
    logic [DW-1:0] pre[32];
    logic [63:0]   r;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // write rows expect sram_wen, read rows expect rsp_rdata
        tbl[0] = '{1'b1, 8'h12, 59'h5A5_A5A5_A5A5_A5A5, ONES, '0};
        tbl[1] = '{1'b0, 8'h12, '0, '0, 59'h5A5_A5A5_A5A5_A5A5};
        tbl[2] = '{1'b1, 8'h12, ONES, 59'hFF, ~59'hFF};
        tbl[3] = '{1'b0, 8'h12, '0, '0, 59'h5A5_A5A5_A5A5_A5FF};
        tbl[4] = '{1'b1, 8'h07, ONES, ONES, '0};
        tbl[5] = '{1'b1, 8'h07, '0, '0, ONES};
        tbl[6] = '{1'b0, 8'h07, '0, '0, ONES};
        tbl[7] = '{1'b1, 8'h07, '0, 59'h400_0000_0000_0001, ~59'h400_0000_0000_0001};
        tbl[8] = '{1'b0, 8'h07, '0, '0, 59'h3FF_FFFF_FFFF_FFFE};

        repeat (3) step();
        rst_n = 1'b1;
        if (INIT_BUILD) sweep_check("sweep");
        else begin
            step();
            chk("rdy_out_of_reset", req_rdy, 1);
            chk("done_out_of_reset", init_done, 1);
        end

        for (int i = 0; i < 32; i++) begin
            r = {$urandom(), $urandom()};
            pre[i] = r[DW-1:0];
            req_vld = 1'b1;
            req_wr = 1'b1;
            req_addr = AW'(i);
            req_wdata = pre[i];
            req_wmask = ONES;
            step();
        end
        req_vld = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            req_vld = 1'b1;
            req_wr = tbl[i].wr;
            req_addr = tbl[i].addr;
            req_wdata = tbl[i].wdata;
            req_wmask = tbl[i].wmask;
            #1 chk("tbl_rdy", req_rdy, 1);
            step();
            req_vld = 1'b0;
            chk("tbl_cen", sram_cen, 0);
            chk("tbl_gwen", sram_gwen, !tbl[i].wr);
            chk("tbl_a", sram_a, tbl[i].addr);
            chk("tbl_early_vld", rsp_vld, 0);
            if (tbl[i].wr) begin
                chk("tbl_wen", sram_wen, tbl[i].exp);
                chk("tbl_d", sram_d, tbl[i].wdata);
            end else begin
                chk("tbl_rd_wen", sram_wen, ONES);
                step();
                chk("tbl_vld", rsp_vld, 1);
                chk("tbl_rdata", rsp_rdata, tbl[i].exp);
            end
            step();
            chk("tbl_late_vld", rsp_vld, 0);
        end

        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                req_vld = 1'b1;
                req_wr = 1'b0;
                req_addr = AW'(i);
                #1 chk("stream_rdy", req_rdy, 1);
            end else req_vld = 1'b0;
            step();
            chk("stream_vld", rsp_vld, i >= 1 && i <= 3);
            if (i >= 1 && i <= 3) chk("stream_data", rsp_rdata, pre[i-1]);
        end

        req_vld = 1'b1;
        req_wr = 1'b0;
        req_addr = 8'h05;
        step();
        req_addr = 8'h10;
        init_start = 1'b1;
        #1 chk("coll_rdy", req_rdy, !INIT_BUILD);
        step();
        init_start = 1'b0;
        req_vld = 1'b0;
        chk("coll_inflight_vld", rsp_vld, 1);
        chk("coll_inflight_data", rsp_rdata, pre[5]);
        chk("coll_done", init_done, !INIT_BUILD);
        if (INIT_BUILD) sweep_check("resweep");
        else begin
            step();
            chk("coll_rd10_vld", rsp_vld, 1);
            chk("coll_rd10_data", rsp_rdata, pre[16]);
        end
        repeat (2) step();

        if (INIT_BUILD) begin
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            for (int i = 0; i < 300 && !(sram_a == 8'd100 && !sram_cen); i++) step();
            chk("reach_a100", sram_a, 100);
            #2 rst_n = 1'b0;
            #1 chk("midsweep_cen", sram_cen, 1);
            chk("midsweep_done", init_done, 0);
            chk("midsweep_wen", sram_wen, ONES);
            repeat (2) step();
            rst_n = 1'b1;
            step();
            chk("restart_a0", sram_a, 0);
            chk("restart_cen", sram_cen, 0);
            wait_done();
        end

        req_vld = 1'b1;
        req_wr = 1'b0;
        req_addr = 8'h03;
        step();
        req_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("midread_cen", sram_cen, 1);
        chk("midread_vld", rsp_vld, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("midread_dropped", rsp_vld, 0);
        wait_done();

        for (int i = 0; i < 32; i++) begin
            req_vld = 1'b1;
            req_wr = 1'b1;
            req_addr = AW'(i);
            r = {$urandom(), $urandom()};
            req_wdata = r[DW-1:0];
            req_wmask = ONES;
            step();
        end
        for (int i = 0; i < 800; i++) begin
            req_vld = $urandom_range(9) < 7;
            req_wr = 1'($urandom_range(1));
            req_addr = AW'($urandom_range(31));
            r = {$urandom(), $urandom()};
            req_wdata = r[DW-1:0];
            r = {$urandom(), $urandom()};
            case ($urandom_range(3))
                0: req_wmask = '0;
                1: req_wmask = ONES;
                default: req_wmask = r[DW-1:0];
            endcase
            init_start = $urandom_range(199) == 0;
            step();
        end
        req_vld = 1'b0;
        init_start = 1'b0;
        wait_done();
        repeat (4) step();
        chk("rsp_queue_drained", rq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
